// File: rtl/acc_lr_power.sv
// rtl/acc_lr_power.sv - per-bin power integrator: sums ACC_NUM spectra in RAM, streams the last one out
// Two-stage read-modify-write pipeline with S1->S0 forwarding for back-to-back hits on one bin.
module acc_lr_power #(
  parameter int BITWIDTH  = 7,
  parameter int FFT_POINT = 512,
  parameter int ACC_NUM   = 64,
  parameter int ACC_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_sync_in,
  input  logic [BITWIDTH+1:0]  cnt_sync_in,
  input  logic [47:0]          pwr_in,
  output logic                 en_sync_out,
  output logic [BITWIDTH+1:0]  cnt_sync_out,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 frame_done,
  output logic                 sat_flag
);

  localparam int AW = BITWIDTH + 2;
  localparam int TW = (ACC_NUM > 1) ? $clog2(ACC_NUM) : 1;
  localparam logic [TW-1:0] LAST_TAG = TW'(ACC_NUM - 1);
  localparam logic [AW-1:0] LAST_BIN = AW'(FFT_POINT - 1);
  localparam logic [31:0]   NPTS     = 32'(FFT_POINT);

  // Depth covers the full index range so any cnt_sync_in value is a legal index;
  // entries at or above FFT_POINT are never written.
  logic [ACC_WIDTH-1:0] mem [0:(2**AW)-1];
  logic [ACC_WIDTH-1:0] ram_q;

  logic [TW-1:0]        frame_cnt;
  logic                 in_ok;
  logic                 s1_valid;
  logic [AW-1:0]        s1_bin;
  logic [47:0]          s1_pwr;
  logic [TW-1:0]        s1_tag;

  logic [ACC_WIDTH:0]   pwr_ext;
  logic [ACC_WIDTH:0]   sum_full;
  logic                 sat_hit;
  logic [ACC_WIDTH-1:0] sum;
  logic                 out_now;

  assign in_ok = en_sync_in && ({{(32-AW){1'b0}}, cnt_sync_in} < NPTS);

  always_comb begin
    pwr_ext  = (ACC_WIDTH+1)'(s1_pwr);
    sum_full = (s1_tag == '0) ? pwr_ext : ({1'b0, ram_q} + pwr_ext);
    sat_hit  = sum_full[ACC_WIDTH];
    sum      = sat_hit ? {ACC_WIDTH{1'b1}} : sum_full[ACC_WIDTH-1:0];
    out_now  = s1_valid && (s1_tag == LAST_TAG);
  end

  // RAM is left uninitialised: frame 0 overwrites every bin before it is read back.
  always_ff @(posedge clk) begin
    if (s1_valid) begin
      mem[s1_bin] <= sum;
    end
    if (in_ok) begin
      ram_q <= (s1_valid && (s1_bin == cnt_sync_in)) ? sum : mem[cnt_sync_in];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt    <= '0;
      s1_valid     <= 1'b0;
      s1_bin       <= '0;
      s1_pwr       <= '0;
      s1_tag       <= '0;
      en_sync_out  <= 1'b0;
      cnt_sync_out <= '0;
      acc_out      <= '0;
      frame_done   <= 1'b0;
      sat_flag     <= 1'b0;
    end else begin
      s1_valid <= in_ok;
      if (in_ok) begin
        s1_bin <= cnt_sync_in;
        s1_pwr <= pwr_in;
        s1_tag <= frame_cnt;
        if (cnt_sync_in == LAST_BIN) begin
          frame_cnt <= (frame_cnt == LAST_TAG) ? '0 : frame_cnt + 1'b1;
        end
      end

      en_sync_out <= out_now;
      frame_done  <= out_now && (s1_bin == LAST_BIN);
      if (out_now) begin
        acc_out      <= sum;
        cnt_sync_out <= s1_bin;
      end

      // A tag-0 sum is never saturated, so clearing on the first bin of a new
      // integration only drops history from integrations already streamed out.
      if (s1_valid) begin
        if ((s1_tag == '0) && (s1_bin == '0)) begin
          sat_flag <= 1'b0;
        end else if (sat_hit) begin
          sat_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_lr_power.sv
// tb/tb_acc_lr_power.sv - directed self-checking bench for acc_lr_power
// Main instance: FFT_POINT=8, ACC_NUM=4; two single-bin instances cover pass-through and forwarding.
module tb_acc_lr_power;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_sync_in = 1'b0;
  logic [2:0]  cnt_sync_in = '0;
  logic [47:0] pwr_in = '0;
  logic [2:0]  zero_bin = '0;

  logic        en_sync_out, frame_done, sat_flag;
  logic [2:0]  cnt_sync_out;
  logic [47:0] acc_out;

  logic        a1_en, a1_fd, a1_sat;
  logic [2:0]  a1_cnt;
  logic [47:0] a1_acc;
  logic        a2_en, a2_fd, a2_sat;
  logic [2:0]  a2_cnt;
  logic [47:0] a2_acc;

  acc_lr_power #(.BITWIDTH(1), .FFT_POINT(8), .ACC_NUM(4), .ACC_WIDTH(48)) dut (
    .clk(clk), .rst(rst), .en_sync_in(en_sync_in), .cnt_sync_in(cnt_sync_in), .pwr_in(pwr_in),
    .en_sync_out(en_sync_out), .cnt_sync_out(cnt_sync_out), .acc_out(acc_out),
    .frame_done(frame_done), .sat_flag(sat_flag));

  acc_lr_power #(.BITWIDTH(1), .FFT_POINT(1), .ACC_NUM(1), .ACC_WIDTH(48)) dut_a1 (
    .clk(clk), .rst(rst), .en_sync_in(en_sync_in), .cnt_sync_in(zero_bin), .pwr_in(pwr_in),
    .en_sync_out(a1_en), .cnt_sync_out(a1_cnt), .acc_out(a1_acc),
    .frame_done(a1_fd), .sat_flag(a1_sat));

  acc_lr_power #(.BITWIDTH(1), .FFT_POINT(1), .ACC_NUM(2), .ACC_WIDTH(48)) dut_a2 (
    .clk(clk), .rst(rst), .en_sync_in(en_sync_in), .cnt_sync_in(zero_bin), .pwr_in(pwr_in),
    .en_sync_out(a2_en), .cnt_sync_out(a2_cnt), .acc_out(a2_acc),
    .frame_done(a2_fd), .sat_flag(a2_sat));

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] acc;
    logic [2:0]  bin;
    logic        fd;
    int          cyc;
  } out_t;

  out_t q[$];
  out_t qa1[$];
  out_t qa2[$];
  int   cyc = 0;
  int   fd_cnt = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   spec_start = 0;
  int   issue[6];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (en_sync_out) q.push_back('{acc_out, cnt_sync_out, frame_done, cyc});
    if (frame_done) fd_cnt = fd_cnt + 1;
    if (a1_en) qa1.push_back('{a1_acc, a1_cnt, a1_fd, cyc});
    if (a2_en) qa2.push_back('{a2_acc, a2_cnt, a2_fd, cyc});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and are captured at the next one.
  task automatic drive(input bit en, input int bin, input logic [47:0] p);
    en_sync_in  = en;
    cnt_sync_in = 3'(bin);
    pwr_in      = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 48'd0);
  endtask

  task automatic send_spec(input logic [47:0] base, input int step, input bit gap);
    spec_start = cyc;
    for (int b = 0; b < 8; b++) begin
      drive(1'b1, b, base + 48'(step * b));
      if (gap) idle(1);
    end
  endtask

  task automatic check_const(input string tag, input logic [47:0] exp, input int spacing);
    chk({tag, "_count"}, 64'(q.size()), 64'd8);
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      chk({tag, "_acc"}, 64'(q[i].acc), 64'(exp));
      chk({tag, "_bin"}, 64'(q[i].bin), 64'(i));
      if (spacing > 0 && i > 0) chk({tag, "_spacing"}, 64'(q[i].cyc - q[i-1].cyc), 64'(spacing));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en_out", 64'(en_sync_out), 64'd0);
    chk("rst_acc_out", 64'(acc_out), 64'd0);
    chk("rst_cnt_out", 64'(cnt_sync_out), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_sat_flag", 64'(sat_flag), 64'd0);
    rst = 1'b1;
    idle(2);

    // 1: four spectra of 5 -> 20 per bin, first output 2 clk after bin 0 of the last spectrum
    q.delete();
    fd_cnt = 0;
    for (int k = 0; k < 4; k++) send_spec(48'd5, 0, 1'b0);
    idle(4);
    check_const("t1", 48'd20, 1);
    for (int i = 0; i < 8 && i < q.size(); i++) chk("t1_frame_done", 64'(q[i].fd), 64'(i == 7));
    if (q.size() > 0) chk("t1_latency", 64'(q[0].cyc - spec_start), 64'd2);
    chk("t1_fd_pulses", 64'(fd_cnt), 64'd1);
    chk("t1_hold_en", 64'(en_sync_out), 64'd0);
    chk("t1_hold_acc", 64'(acc_out), 64'd20);
    chk("t1_hold_cnt", 64'(cnt_sync_out), 64'd7);

    // 2: spectrum k bin b = 10k+b over two integrations
    q.delete();
    for (int k = 0; k < 8; k++) send_spec(48'(k * 10), 1, 1'b0);
    idle(4);
    chk("t2_count", 64'(q.size()), 64'd16);
    for (int i = 0; i < 16 && i < q.size(); i++) begin
      chk("t2_acc", 64'(q[i].acc), 64'((i < 8 ? 60 : 220) + 4 * (i % 8)));
      chk("t2_bin", 64'(q[i].bin), 64'(i % 8));
    end

    // 3: valid toggling every cycle
    q.delete();
    for (int k = 0; k < 4; k++) send_spec(48'd5, 0, 1'b1);
    idle(4);
    check_const("t3", 48'd20, 2);

    // 4: saturation, then a clean integration clears sat_flag after its bin 0
    q.delete();
    chk("t4_sat_before", 64'(sat_flag), 64'd0);
    for (int k = 0; k < 4; k++) send_spec(48'h8000_0000_0000, 0, 1'b0);
    idle(4);
    check_const("t4_sat", 48'hFFFF_FFFF_FFFF, 1);
    chk("t4_sat_set", 64'(sat_flag), 64'd1);
    q.delete();
    drive(1'b1, 0, 48'd1);
    idle(1);
    chk("t4_sat_cleared", 64'(sat_flag), 64'd0);
    for (int b = 1; b < 8; b++) drive(1'b1, b, 48'd1);
    for (int k = 1; k < 4; k++) send_spec(48'd1, 0, 1'b0);
    idle(4);
    check_const("t4_clean", 48'd4, 1);
    chk("t4_sat_end", 64'(sat_flag), 64'd0);

    // 5: asynchronous reset during the third spectrum discards the partial integration
    send_spec(48'd7, 0, 1'b0);
    send_spec(48'd7, 0, 1'b0);
    for (int b = 0; b < 3; b++) drive(1'b1, b, 48'd7);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_acc", 64'(acc_out), 64'd0);
    chk("t5_rst_cnt", 64'(cnt_sync_out), 64'd0);
    chk("t5_rst_en", 64'(en_sync_out), 64'd0);
    en_sync_in = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    for (int k = 0; k < 4; k++) send_spec(48'd3, 0, 1'b0);
    idle(4);
    check_const("t5", 48'd12, 1);

    // 6: single-bin instances, same bin every cycle
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(1);
    qa1.delete();
    qa2.delete();
    for (int i = 0; i < 6; i++) begin
      issue[i] = cyc;
      drive(1'b1, 0, 48'(11 * (i + 1)));
    end
    idle(4);
    chk("t6_a1_count", 64'(qa1.size()), 64'd6);
    for (int i = 0; i < 6 && i < qa1.size(); i++) begin
      chk("t6_a1_acc", 64'(qa1[i].acc), 64'(11 * (i + 1)));
      chk("t6_a1_lat", 64'(qa1[i].cyc - issue[i]), 64'd2);
    end
    chk("t6_a2_count", 64'(qa2.size()), 64'd3);
    for (int i = 0; i < 3 && i < qa2.size(); i++) begin
      chk("t6_a2_acc", 64'(qa2[i].acc), 64'(11 * (2 * i + 1) + 11 * (2 * i + 2)));
      chk("t6_a2_lat", 64'(qa2[i].cyc - issue[2 * i + 1]), 64'd2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
